game_seq_ctrl: RTL and testbench

GAME_SEQ_CTRL -- requirements
Module: game_seq_ctrl

---
 rtl/game_pkg.sv | 45 ++++
 rtl/bcd_score_acc.sv | 47 ++++
 rtl/game_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_game_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the game sequencing controller.
// State codes, BCD point values, default timing and a BCD adder.
package game_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READY     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_DYING     = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam logic [15:0] PTS_DOT   = 16'h0010;
  localparam logic [15:0] PTS_POWER = 16'h0050;
  localparam logic [15:0] PTS_GHOST = 16'h0200;
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  localparam int DEF_TICK_DIV     = 4;
  localparam int DEF_START_LIVES  = 3;
  localparam int DEF_READY_FRAMES = 120;
  localparam int DEF_DYING_FRAMES = 90;

  // 4-digit packed BCD add; bit 16 is the carry out of the top digit
  function automatic logic [16:0] bcd_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] r;
    logic [4:0]  d;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = d[3:0];
    end
    r[16] = c;
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_acc.sv
// Packed-BCD score accumulator.
// Adds the points of all events in one cycle and saturates at 9999.
module bcd_score_acc
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        dot,
  input  logic        power,
  input  logic        ghost,
  input  logic        enable,
  output logic [15:0] score
);

  logic [15:0] add_dot;
  logic [15:0] add_pow;
  logic [15:0] add_gh;
  logic [16:0] sum_dp;
  logic [16:0] sum_pts;
  logic [16:0] sum_all;
  logic        any_evt;

  always_comb begin
    add_dot = dot   ? PTS_DOT   : 16'h0000;
    add_pow = power ? PTS_POWER : 16'h0000;
    add_gh  = ghost ? PTS_GHOST : 16'h0000;
    sum_dp  = bcd_add(add_dot, add_pow);
    sum_pts = bcd_add(sum_dp[15:0], add_gh);
    sum_all = bcd_add(score, sum_pts[15:0]);
    any_evt = dot | power | ghost;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score <= 16'h0000;
    end else if (clear) begin
      score <= 16'h0000;
    end else if (enable && any_evt) begin
      if (sum_all[16] | sum_pts[16] | sum_dp[16])
        score <= SCORE_MAX;
      else
        score <= sum_all[15:0];
    end
  end

endmodule

// File: rtl/game_seq_ctrl.sv
// Game sequencing controller: start/ready/play/dying/game-over flow,
// logic step pacing, lives and BCD score.
module game_seq_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int START_LIVES  = DEF_START_LIVES,
  parameter int READY_FRAMES = DEF_READY_FRAMES,
  parameter int DYING_FRAMES = DEF_DYING_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        btn_c,
  input  logic        pacman_dead,
  input  logic        dot_eaten,
  input  logic        power_eaten,
  input  logic        ghost_eaten,
  input  logic        level_clear,
  output logic        logic_step,
  output logic        logic_rst_n,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic        show_ready,
  output logic        show_game_over
);

  localparam logic [3:0] TICK_N  = 4'(TICK_DIV);
  localparam logic [1:0] LIVES_N = 2'(START_LIVES);
  localparam logic [7:0] READY_N = 8'(READY_FRAMES);
  localparam logic [7:0] DYING_N = 8'(DYING_FRAMES);

  logic       btn_s1;
  logic       btn_s2;
  logic       btn_s3;
  logic [1:0] warm;
  logic       start_edge;

  logic [2:0] state_nxt;
  logic [7:0] fcnt;
  logic [7:0] fcnt_inc;
  logic [3:0] scnt;
  logic [3:0] scnt_inc;
  logic       in_idle;
  logic       in_ready;
  logic       in_play;
  logic       in_dying;
  logic       in_go;
  logic       do_start;
  logic       step_wrap;

  // warm keeps a button held through reset from looking like a new press
  assign start_edge = btn_s2 & ~btn_s3 & (warm == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
      warm   <= 2'd0;
    end else begin
      btn_s1 <= btn_c;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      if (warm != 2'd3)
        warm <= warm + 2'd1;
    end
  end

  assign in_idle  = (state == ST_IDLE);
  assign in_ready = (state == ST_READY);
  assign in_play  = (state == ST_PLAY);
  assign in_dying = (state == ST_DYING);
  assign in_go    = (state == ST_GAME_OVER);

  always_comb begin
    fcnt_inc  = fcnt + 8'd1;
    scnt_inc  = scnt + 4'd1;
    step_wrap = (scnt_inc == TICK_N);
    do_start  = (in_idle | in_go) & start_edge;
    state_nxt = state;
    case (state)
      ST_IDLE,
      ST_GAME_OVER: begin
        if (start_edge)
          state_nxt = ST_READY;
      end
      ST_READY: begin
        if (frame_start && fcnt_inc == READY_N)
          state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (pacman_dead)
          state_nxt = ST_DYING;
        else if (level_clear)
          state_nxt = ST_READY;
      end
      ST_DYING: begin
        if (frame_start && fcnt_inc == DYING_N)
          state_nxt = (lives == 2'd0) ? ST_GAME_OVER : ST_READY;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      fcnt           <= 8'd0;
      scnt           <= 4'd0;
      lives          <= 2'd0;
      logic_step     <= 1'b0;
      logic_rst_n    <= 1'b0;
      show_ready     <= 1'b0;
      show_game_over <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)
        fcnt <= 8'd0;
      else if (frame_start && (in_ready | in_dying))
        fcnt <= fcnt_inc;

      if (!in_play)
        scnt <= 4'd0;
      else if (frame_start)
        scnt <= step_wrap ? 4'd0 : scnt_inc;

      if (do_start)
        lives <= LIVES_N;
      else if (in_play && pacman_dead && lives != 2'd0)
        lives <= lives - 2'd1;

      logic_step <= in_play & (state_nxt == ST_PLAY)
                  & frame_start & step_wrap;

      logic_rst_n    <= (state_nxt == ST_PLAY) |
                        (state_nxt == ST_DYING);
      show_ready     <= (state_nxt == ST_READY);
      show_game_over <= (state_nxt == ST_GAME_OVER);
    end
  end

  bcd_score_acc u_score (
    .clk    (clk),
    .rst    (rst),
    .clear  (do_start),
    .dot    (dot_eaten),
    .power  (power_eaten),
    .ghost  (ghost_eaten),
    .enable (in_play),
    .score  (score)
  );

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Bench for game_seq_ctrl: directed scenarios plus random play,
// all checked each cycle against a decimal reference model.
module tb_game_seq_ctrl;

  localparam int TD = 2;
  localparam int SL = 2;
  localparam int RF = 3;
  localparam int DF = 4;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        btn_c;
  logic        pacman_dead;
  logic        dot_eaten;
  logic        power_eaten;
  logic        ghost_eaten;
  logic        level_clear;
  logic        logic_step;
  logic        logic_rst_n;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [15:0] score;
  logic        show_ready;
  logic        show_game_over;

  int tests;
  int fails;

  // reference model: states 0 idle,1 ready,2 play,3 dying,4 over
  int m_state;
  int m_lives;
  int m_score;
  int m_fcnt;
  int m_scnt;
  int m_step;
  int n_edges;
  bit hist[$];

  game_seq_ctrl #(
    .TICK_DIV     (TD),
    .START_LIVES  (SL),
    .READY_FRAMES (RF),
    .DYING_FRAMES (DF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .btn_c          (btn_c),
    .pacman_dead    (pacman_dead),
    .dot_eaten      (dot_eaten),
    .power_eaten    (power_eaten),
    .ghost_eaten    (ghost_eaten),
    .level_clear    (level_clear),
    .logic_step     (logic_step),
    .logic_rst_n    (logic_rst_n),
    .state          (state),
    .lives          (lives),
    .score          (score),
    .show_ready     (show_ready),
    .show_game_over (show_game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_lives = 0;
    m_score = 0;
    m_fcnt  = 0;
    m_scnt  = 0;
    m_step  = 0;
    n_edges = 0;
    hist.delete();
  endtask

  task automatic check_all();
    check("state", 16'(state), 16'(m_state));
    check("lives", 16'(lives), 16'(m_lives));
    check("score", score, to_bcd(m_score));
    check("logic_step", 16'(logic_step), 16'(m_step));
    check("logic_rst_n", 16'(logic_rst_n),
          16'(m_state == 2 || m_state == 3));
    check("show_ready", 16'(show_ready), 16'(m_state == 1));
    check("show_game_over", 16'(show_game_over), 16'(m_state == 4));
  endtask

  // called at a falling edge: drive, predict next rising edge, check
  task automatic cyc(input bit fs, input bit dead, input bit d,
                     input bit p, input bit g, input bit lc);
    int  ns;
    bit  start;
    int  pts;
    frame_start = fs;
    pacman_dead = dead;
    dot_eaten   = d;
    power_eaten = p;
    ghost_eaten = g;
    level_clear = lc;
    n_edges++;
    hist.push_back(btn_c);
    start = (n_edges >= 4) && hist[n_edges-3] && !hist[n_edges-4];
    pts = 10 * int'(d) + 50 * int'(p) + 200 * int'(g);
    if (m_state == 2)
      m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
    ns = m_state;
    m_step = 0;
    case (m_state)
      0, 4: if (start) begin
        ns = 1;
        m_score = 0;
        m_lives = SL;
      end
      1: if (fs) begin
        m_fcnt++;
        if (m_fcnt == RF) ns = 2;
      end
      2: if (dead) begin
        ns = 3;
        if (m_lives > 0) m_lives--;
      end else if (lc) begin
        ns = 1;
      end else if (fs) begin
        m_scnt++;
        if (m_scnt == TD) begin
          m_scnt = 0;
          m_step = 1;
        end
      end
      3: if (fs) begin
        m_fcnt++;
        if (m_fcnt == DF) ns = (m_lives == 0) ? 4 : 1;
      end
      default: ns = 0;
    endcase
    if (ns != m_state) begin
      m_fcnt = 0;
      m_scnt = 0;
    end
    m_state = ns;
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_now();
    rst = 1'b0;
    #1;
    check("rst_state", 16'(state), 16'd0);
    check("rst_score", score, 16'h0000);
    check("rst_lives", 16'(lives), 16'd0);
    check("rst_step", 16'(logic_step), 16'd0);
    check("rst_logic_rst_n", 16'(logic_rst_n), 16'd0);
    check("rst_show", 16'({show_ready, show_game_over}), 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until(input int target, input int budget,
                           input string tag);
    int k;
    k = 0;
    while (m_state != target && k < budget) begin
      cyc(k[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    check(tag, 16'(state), 16'(target));
  endtask

  task automatic press_start();
    btn_c = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    btn_c = 1'b1;
  endtask

  initial begin
    int fs_cnt;
    int steps;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    btn_c = 1'b1;
    frame_start = 1'b0;
    pacman_dead = 1'b0;
    dot_eaten = 1'b0;
    power_eaten = 1'b0;
    ghost_eaten = 1'b0;
    level_clear = 1'b0;
    reset_now();

    // button held high through reset: no start
    repeat (10) cyc(0, 0, 0, 0, 0, 0);
    check("held_idle", 16'(state), 16'd0);
    check("held_score", score, 16'h0000);
    check("held_rst_n", 16'(logic_rst_n), 16'd0);

    press_start();
    run_until(1, 10, "start_ready");
    check("start_lives", 16'(lives), 16'(SL));

    fs_cnt = 0;
    for (int k = 0; k < 40 && m_state == 1; k++) begin
      if (k % 3 == 2) fs_cnt++;
      cyc(k % 3 == 2, 0, 0, 0, 0, 0);
    end
    check("ready_frames", 16'(fs_cnt), 16'(RF));
    check("in_play", 16'(state), 16'd2);

    steps = 0;
    for (int k = 0; k < 36; k++) begin
      cyc(k % 3 == 0, 0, 0, 0, 0, 0);
      if (logic_step) steps++;
    end
    check("step_count", 16'(steps), 16'd6);

    repeat (9) cyc(0, 0, 1, 0, 0, 0);
    check("score_0090", score, 16'h0090);
    cyc(0, 0, 1, 1, 1, 0);
    check("score_0350", score, 16'h0350);

    repeat (48) cyc(0, 0, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 1, 0, 0, 0);
    check("score_9990", score, 16'h9990);
    cyc(0, 0, 0, 0, 1, 0);
    check("score_sat", score, 16'h9999);
    repeat (3) cyc(0, 0, 1, 1, 1, 0);
    check("score_hold", score, 16'h9999);

    cyc(0, 1, 0, 0, 0, 1);
    check("dead_wins", 16'(state), 16'd3);
    check("dead_lives", 16'(lives), 16'(SL - 1));
    check("dead_score", score, 16'h9999);
    run_until(1, 40, "dying_ready");
    run_until(2, 40, "back_play");
    cyc(0, 1, 0, 0, 0, 0);
    check("last_life", 16'(lives), 16'd0);
    run_until(4, 40, "game_over");
    check("over_flag", 16'(show_game_over), 16'd1);
    press_start();
    run_until(1, 10, "restart");
    check("restart_lives", 16'(lives), 16'(SL));
    check("restart_score", score, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        btn_c = 1'b1;
        reset_now();
      end
      if ($urandom_range(29) == 0) btn_c = ~btn_c;
      cyc($urandom_range(3) == 0,
          (m_state == 2) ? ($urandom_range(59) == 0)
                         : ($urandom_range(3) == 0),
          $urandom_range(3) == 0,
          $urandom_range(3) == 0,
          $urandom_range(3) == 0,
          $urandom_range(79) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
